// File: rtl/data_sram_responder.sv
// Data SRAM target: word RAM plus LED/NUM/SCRATCH register window, one-cycle read-first latency.
// Optional free-running timer at offset F020 enabled by DATA_SRAM_RESP_TIMER_EN.
module data_sram_responder #(
  parameter int unsigned ADDR_W    = 12,
  parameter logic [31:0] MMIO_BASE = 32'hBFAF_0000,
  parameter int unsigned LED_W     = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             data_sram_en,
  input  logic [3:0]       data_sram_we,
  input  logic [31:0]      data_sram_addr,
  input  logic [31:0]      data_sram_wdata,
  output logic [31:0]      data_sram_rdata,
  output logic [LED_W-1:0] led,
  output logic [31:0]      num_data
);

  localparam logic [15:0] OFF_LED = 16'hF000;
  localparam logic [15:0] OFF_NUM = 16'hF010;
  localparam logic [15:0] OFF_TMR = 16'hF020;
  localparam logic [15:0] OFF_SCR = 16'hF030;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  be);
    logic [31:0] r;
    r = old_w;
    for (int unsigned i = 0; i < 4; i++) begin
      if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
    end
    return r;
  endfunction

  logic [31:0]       mem_q [2**ADDR_W];
  logic [31:0]       rdata_q, rdata_d;
  logic [LED_W-1:0]  led_q, led_d;
  logic [31:0]       num_q, num_d;
  logic [31:0]       scratch_q, scratch_d;
  logic [31:0]       led_ext;
  logic [31:0]       rd_word;
  logic              mmio_hit;
  logic [15:0]       off;
  logic [ADDR_W-1:0] ram_idx;
  logic              ram_wr;
  logic              unused_addr_lsb;

  assign mmio_hit        = (data_sram_addr[31:16] == MMIO_BASE[31:16]);
  assign off             = data_sram_addr[15:0];
  assign ram_idx         = data_sram_addr[ADDR_W+1:2];
  assign ram_wr          = data_sram_en && !mmio_hit;
  assign unused_addr_lsb = ^data_sram_addr[1:0];

`ifdef DATA_SRAM_RESP_TIMER_EN
  logic [31:0] timer_q, timer_d;

  always_comb begin
    timer_d = timer_q + 32'd1;
    if (data_sram_en && mmio_hit && off == OFF_TMR)
      timer_d = merge_bytes(timer_q, data_sram_wdata, data_sram_we);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) timer_q <= '0;
    else         timer_q <= timer_d;
  end
`endif

  always_comb begin
    led_ext = '0;
    led_ext[LED_W-1:0] = led_q;
  end

  always_comb begin
    rd_word = '0;
    if (mmio_hit) begin
      case (off)
        OFF_LED: rd_word = led_ext;
        OFF_NUM: rd_word = num_q;
        OFF_SCR: rd_word = scratch_q;
`ifdef DATA_SRAM_RESP_TIMER_EN
        OFF_TMR: rd_word = timer_q;
`endif
        default: rd_word = '0;
      endcase
    end else begin
      rd_word = mem_q[ram_idx];
    end
  end

  always_comb begin
    rdata_d   = data_sram_en ? rd_word : rdata_q;
    led_d     = led_q;
    num_d     = num_q;
    scratch_d = scratch_q;
    if (data_sram_en && mmio_hit) begin
      case (off)
        OFF_LED: begin
          // LED lanes above LED_W have no backing bits and are dropped.
          for (int unsigned i = 0; i < LED_W; i++) begin
            if (data_sram_we[i/8]) led_d[i] = data_sram_wdata[i];
          end
        end
        OFF_NUM: num_d     = merge_bytes(num_q, data_sram_wdata, data_sram_we);
        OFF_SCR: scratch_d = merge_bytes(scratch_q, data_sram_wdata, data_sram_we);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rdata_q   <= '0;
      led_q     <= '0;
      num_q     <= '0;
      scratch_q <= '0;
    end else begin
      rdata_q   <= rdata_d;
      led_q     <= led_d;
      num_q     <= num_d;
      scratch_q <= scratch_d;
    end
  end

  // RAM contents survive reset; the reset branch only blocks a write on a reset edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
    end else if (ram_wr) begin
      mem_q[ram_idx] <= merge_bytes(mem_q[ram_idx], data_sram_wdata, data_sram_we);
    end
  end

  assign data_sram_rdata = rdata_q;
  assign led             = led_q;
  assign num_data        = num_q;

endmodule

// File: tb/tb_data_sram_responder.sv
// Directed bench for data_sram_responder; timer checks compile in with DATA_SRAM_RESP_TIMER_EN.
module tb_data_sram_responder;

  logic        clk;
  logic        resetn;
  logic        en;
  logic [3:0]  we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [15:0] led;
  logic [31:0] num_data;

  int n_cmp  = 0;
  int n_fail = 0;

  data_sram_responder #(
    .ADDR_W    (12),
    .MMIO_BASE (32'hBFAF_0000),
    .LED_W     (16)
  ) dut (
    .clk             (clk),
    .resetn          (resetn),
    .data_sram_en    (en),
    .data_sram_we    (we),
    .data_sram_addr  (addr),
    .data_sram_wdata (wdata),
    .data_sram_rdata (rdata),
    .led             (led),
    .num_data        (num_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drive one request at a negedge, return at the next negedge with results visible.
  task automatic cyc(input logic e, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
    en = e; we = w; addr = a; wdata = d;
    @(negedge clk);
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    cyc(1'b0, 4'h0, 32'h0, 32'h0);
    cyc(1'b0, 4'h0, 32'h0, 32'h0);
    n_cmp++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got=%h exp=%h", rdata, 32'h0); end
    n_cmp++; if (led !== 16'h0) begin n_fail++; $display("FAIL reset_led got=%h exp=%h", led, 16'h0); end
    n_cmp++; if (num_data !== 32'h0) begin n_fail++; $display("FAIL reset_num got=%h exp=%h", num_data, 32'h0); end
    resetn = 1'b1;
  endtask

  task automatic test_ram_rw();
    cyc(1'b1, 4'hF, 32'h0000_0010, 32'h1234_5678);
    cyc(1'b1, 4'h0, 32'h0000_0010, 32'h0);
    n_cmp++; if (rdata !== 32'h1234_5678) begin n_fail++; $display("FAIL ram_read got=%h exp=%h", rdata, 32'h1234_5678); end
    // aliasing: 0x4030 maps to the same word as 0x30
    cyc(1'b1, 4'hF, 32'h0000_0030, 32'hCAFE_F00D);
    cyc(1'b1, 4'h0, 32'h0000_4030, 32'h0);
    n_cmp++; if (rdata !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL ram_alias got=%h exp=%h", rdata, 32'hCAFE_F00D); end
  endtask

  task automatic test_byte_merge();
    cyc(1'b1, 4'b0101, 32'h0000_0010, 32'hAABB_CCDD);
    n_cmp++; if (rdata !== 32'h1234_5678) begin n_fail++; $display("FAIL merge_readfirst got=%h exp=%h", rdata, 32'h1234_5678); end
    cyc(1'b1, 4'h0, 32'h0000_0010, 32'h0);
    n_cmp++; if (rdata !== 32'h12BB_56DD) begin n_fail++; $display("FAIL merge_result got=%h exp=%h", rdata, 32'h12BB_56DD); end
  endtask

  task automatic test_back_to_back();
    cyc(1'b1, 4'hF, 32'h0000_0020, 32'h0000_0001);
    cyc(1'b1, 4'hF, 32'h0000_0020, 32'h0000_0002);
    n_cmp++; if (rdata !== 32'h1) begin n_fail++; $display("FAIL read_first got=%h exp=%h", rdata, 32'h1); end
    cyc(1'b1, 4'h0, 32'h0000_0020, 32'h0);
    n_cmp++; if (rdata !== 32'h2) begin n_fail++; $display("FAIL b2b_read got=%h exp=%h", rdata, 32'h2); end
  endtask

  task automatic test_mmio();
    cyc(1'b1, 4'hF, 32'hBFAF_F000, 32'hFFFF_00A5);
    n_cmp++; if (led !== 16'h00A5) begin n_fail++; $display("FAIL led_write got=%h exp=%h", led, 16'h00A5); end
    cyc(1'b1, 4'b1100, 32'hBFAF_F000, 32'hFFFF_FFFF);
    n_cmp++; if (led !== 16'h00A5) begin n_fail++; $display("FAIL led_high_lanes got=%h exp=%h", led, 16'h00A5); end
    cyc(1'b1, 4'b0010, 32'hBFAF_F000, 32'h0000_3C00);
    n_cmp++; if (led !== 16'h3CA5) begin n_fail++; $display("FAIL led_merge got=%h exp=%h", led, 16'h3CA5); end
    cyc(1'b1, 4'hF, 32'hBFAF_F010, 32'hDEAD_BEEF);
    n_cmp++; if (num_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL num_write got=%h exp=%h", num_data, 32'hDEAD_BEEF); end
    cyc(1'b1, 4'h0, 32'hBFAF_F010, 32'h0);
    n_cmp++; if (rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL num_read got=%h exp=%h", rdata, 32'hDEAD_BEEF); end
    cyc(1'b0, 4'h0, 32'h0000_0010, 32'h0);
    cyc(1'b0, 4'hF, 32'hBFAF_F010, 32'h0);
    n_cmp++; if (rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rdata_hold got=%h exp=%h", rdata, 32'hDEAD_BEEF); end
    n_cmp++; if (num_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL num_en0_write got=%h exp=%h", num_data, 32'hDEAD_BEEF); end
    cyc(1'b1, 4'h0, 32'hBFAF_F040, 32'h0);
    n_cmp++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL unmapped_read got=%h exp=%h", rdata, 32'h0); end
    cyc(1'b0, 4'hF, 32'hBFAF_F030, 32'h1234_5678);
    cyc(1'b1, 4'h0, 32'hBFAF_F030, 32'h0);
    n_cmp++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL scratch_en0 got=%h exp=%h", rdata, 32'h0); end
    cyc(1'b1, 4'b1000, 32'hBFAF_F030, 32'h1122_3344);
    cyc(1'b1, 4'h0, 32'hBFAF_F030, 32'h0);
    n_cmp++; if (rdata !== 32'h1100_0000) begin n_fail++; $display("FAIL scratch_merge got=%h exp=%h", rdata, 32'h1100_0000); end
    cyc(1'b1, 4'h0, 32'hBFAF_F000, 32'h0);
    n_cmp++; if (rdata !== 32'h0000_3CA5) begin n_fail++; $display("FAIL led_read got=%h exp=%h", rdata, 32'h0000_3CA5); end
    // just outside the window: goes to RAM index 0xC04, registers untouched
    cyc(1'b1, 4'hF, 32'hBFAE_F010, 32'h0000_0077);
    n_cmp++; if (num_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL decode_miss_num got=%h exp=%h", num_data, 32'hDEAD_BEEF); end
    cyc(1'b1, 4'h0, 32'h0000_3010, 32'h0);
    n_cmp++; if (rdata !== 32'h0000_0077) begin n_fail++; $display("FAIL decode_miss_ram got=%h exp=%h", rdata, 32'h0000_0077); end
  endtask

  task automatic test_timer();
`ifdef DATA_SRAM_RESP_TIMER_EN
    cyc(1'b1, 4'hF, 32'hBFAF_F020, 32'hFFFF_FFFE);
    cyc(1'b0, 4'h0, 32'h0, 32'h0);
    cyc(1'b0, 4'h0, 32'h0, 32'h0);
    cyc(1'b1, 4'h0, 32'hBFAF_F020, 32'h0);
    n_cmp++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL timer_wrap got=%h exp=%h", rdata, 32'h0); end
    cyc(1'b1, 4'h0, 32'hBFAF_F020, 32'h0);
    n_cmp++; if (rdata !== 32'h1) begin n_fail++; $display("FAIL timer_inc got=%h exp=%h", rdata, 32'h1); end
`else
    cyc(1'b1, 4'hF, 32'hBFAF_F020, 32'hFFFF_FFFE);
    cyc(1'b1, 4'h0, 32'hBFAF_F020, 32'h0);
    n_cmp++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL timer_absent got=%h exp=%h", rdata, 32'h0); end
`endif
  endtask

  task automatic test_reset_mid();
    cyc(1'b1, 4'h0, 32'hBFAF_F010, 32'h0);
    en = 1'b1; we = 4'hF; addr = 32'hBFAF_F010; wdata = 32'h0000_0055;
    #2 resetn = 1'b0;
    #1;
    n_cmp++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL midreset_rdata got=%h exp=%h", rdata, 32'h0); end
    n_cmp++; if (led !== 16'h0) begin n_fail++; $display("FAIL midreset_led got=%h exp=%h", led, 16'h0); end
    n_cmp++; if (num_data !== 32'h0) begin n_fail++; $display("FAIL midreset_num got=%h exp=%h", num_data, 32'h0); end
    @(negedge clk);
    n_cmp++; if (num_data !== 32'h0) begin n_fail++; $display("FAIL midreset_discard got=%h exp=%h", num_data, 32'h0); end
    resetn = 1'b1;
    cyc(1'b1, 4'h0, 32'hBFAF_F020, 32'h0);
    n_cmp++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL midreset_timer got=%h exp=%h", rdata, 32'h0); end
    cyc(1'b1, 4'h0, 32'hBFAF_F010, 32'h0);
    n_cmp++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL midreset_num_read got=%h exp=%h", rdata, 32'h0); end
  endtask

  initial begin
    resetn = 1'b0; en = 1'b0; we = 4'h0; addr = 32'h0; wdata = 32'h0;
    @(negedge clk);
    test_reset();
    test_ram_rw();
    test_byte_merge();
    test_back_to_back();
    test_mmio();
    test_timer();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/data_sram_responder.md
Name: data_sram_responder

Overview:
- Target end of the CPU's data SRAM interface; the CPU core is the initiator.
- Responds to en/we/addr/wdata requests with the fixed one-cycle read latency the core expects.
- Combines a word-addressed data RAM with a small memory-mapped register window: LED, number display, scratch and optional timer.
- Instantiated beside the CPU top in the SoC wrapper.

Parameters:
- ADDR_W, 12, word-index width of data RAM (2^ADDR_W 32-bit words).
- MMIO_BASE, 32'hBFAF_0000, base of register window; decode compares addr[31:16] only.
- LED_W, 16, width of LED register/output (1..32).

Ports:
- clk  input  1  clock, all state on rising edge
- resetn  input  1  asynchronous active-low reset
- data_sram_en  input  1  request valid this cycle
- data_sram_we  input  4  byte-lane write enables, lane i = wdata[8i+7:8i]
- data_sram_addr  input  32  byte address, addr[1:0] ignored
- data_sram_wdata  input  32  write data
- data_sram_rdata  output  32  read data, registered, valid the cycle after request
- led  output  LED_W  LED register value
- num_data  output  32  number-display register value

Behaviour:
- Reset: asynchronous on resetn low.
  - Reset values: rdata=0, led=0, num_data=0, scratch=0, timer=0.
  - RAM contents are not reset.
- Decode:
  - MMIO hit when addr[31:16]==MMIO_BASE[31:16].
  - Otherwise RAM, index = addr[ADDR_W+1:2]; upper bits ignored, so RAM aliases.
- MMIO offsets (addr[15:0]):
  - 16'hF000 LED
  - 16'hF010 NUM
  - 16'hF020 TIMER (optional feature)
  - 16'hF030 SCRATCH
  - All other offsets: read 0, writes ignored.
- Request accepted every cycle en=1; no stall, no backpressure.
- Writes require en=1; en=0 with we!=0 has no effect.
- Byte-lane merge:
  - For each set we[i], byte i of the target is replaced by wdata byte i; other bytes are kept.
  - Applies to RAM and to every register.
  - LED keeps only its low LED_W bits; lanes above LED_W are dropped.
- Read latency 1:
  - At the edge where en=1 is sampled, rdata <= selected word.
  - Read-first: if the same request writes, rdata gets the pre-write value.
  - This holds for RAM and MMIO alike.
- rdata holds its last value while en=0.
- Read with we!=0 still updates rdata (core ignores it).
- Back-to-back requests:
  - A read at cycle n+1 of an address written at cycle n returns the new data.
  - There is no hazard window.
- Reset mid-operation: a pending write on the edge where reset asserts is discarded; rdata forced to 0 immediately.

Optional Feature:
- Macro: DATA_SRAM_RESP_TIMER_EN.
- Defined:
  - 32-bit free-running timer at offset F020 increments by 1 every cycle out of reset, wraps 32'hFFFF_FFFF -> 0.
  - Write to F020 loads the byte-merged value instead of incrementing that cycle; the next cycle resumes incrementing from the loaded value.
  - Read returns the value before that edge's update.
- Not defined: timer logic absent; F020 reads 0, writes ignored.

Test Plan:
- Reset then read RAM: write 32'h1234_5678 at addr 0x0000_0010 with we=4'hF, next cycle read addr 0x10 -> rdata=32'h1234_5678 one cycle after the read request.
- Byte merge: with word 0x10 = 32'h1234_5678, write we=4'b0101, wdata=32'hAABB_CCDD -> subsequent read gives 32'h12BB_56DD.
- Read-first: word 0x20 = 32'h1, single request en=1, we=4'hF, wdata=32'h2 at 0x20 -> rdata=32'h1 next cycle; following read gives 32'h2.
- MMIO:
  - Write 32'hFFFF_00A5 to 0xBFAF_F000 -> led=16'h00A5 next cycle.
  - Write 32'hDEAD_BEEF to 0xBFAF_F010 -> num_data=32'hDEAD_BEEF.
  - Read 0xBFAF_F040 -> rdata=0.
  - en=0 with we=4'hF to 0xBFAF_F030 -> scratch stays 0.
- Timer (macro defined):
  - Write 32'hFFFF_FFFE to 0xBFAF_F020, then idle 2 cycles, then read -> value 32'h0 (wrap observed).
  - Assert resetn=0 mid-sequence -> rdata, led, num_data, timer all 0 immediately, without waiting for a clock edge.
